neighbor_scan: RTL and testbench

Sequencer that feeds the winner-policy block from the initiator side. On a start pulse it reads this node's neighbor table from word memory and finds the best (lowest-value) neighbor. It counts the neighbors better than the node's own estimate, then issues the start/done handshake to the winner-policy block and latches the returned next hop. It sits between the routing top-level controller and the winner-policy block and shares the memory read port.

---
 rtl/neighbor_scan.sv | 247 ++++++++++++++++++++++++
 tb/tb_neighbor_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_scan.sv
`default_nettype none
// ============================================================================
// Module   : neighbor_scan
// Purpose  : Initiator-side sequencer for the winner-policy block. On start it
//            walks this node's neighbor table in word memory, tracks the
//            lowest-value neighbor (ignoring its own ID), counts neighbors
//            better than the node's own estimate, then runs the start/done
//            handshake with the winner-policy block and latches the next hop.
// Ports    : clock, rst (async, active-high)
//            start, mybest, MY_NODE_ID           - request and node context
//            address / mem_data_out              - shared memory read port
//            start_winnerPolicy / done_winnerPolicy / nexthop_wp
//                                                - winner-policy handshake
//            bestvalue, besthop, bestneighborID,
//            betterNeighborCount, nexthop        - results
//            busy, done, err                     - status
// Revision : 1.0 - initial release
// ============================================================================
module neighbor_scan #(
    parameter int                        WORD_WIDTH    = 16,
    parameter logic [WORD_WIDTH-1:0]     TABLE_BASE    = 16'h0100,
    parameter int                        ADDR_STEP     = 2,
    parameter int                        MAX_NEIGHBORS = 16,
    parameter int                        TIMEOUT       = 255
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] mybest,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    output logic [WORD_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  start_winnerPolicy,
    input  logic                  done_winnerPolicy,
    input  logic [WORD_WIDTH-1:0] nexthop_wp,
    output logic [WORD_WIDTH-1:0] bestvalue,
    output logic [WORD_WIDTH-1:0] besthop,
    output logic [WORD_WIDTH-1:0] bestneighborID,
    output logic [WORD_WIDTH-1:0] betterNeighborCount,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CNT_A = 4'd1,
        CNT_D = 4'd2,
        ID_A  = 4'd3,
        ID_D  = 4'd4,
        VAL_A = 4'd5,
        VAL_D = 4'd6,
        HOP_A = 4'd7,
        HOP_D = 4'd8,
        KICK  = 4'd9,
        WAIT  = 4'd10,
        FIN   = 4'd11
    } state_t;

    localparam logic [WORD_WIDTH-1:0] ALL_ONES     = '1;
    localparam logic [WORD_WIDTH-1:0] STEP         = WORD_WIDTH'(ADDR_STEP);
    localparam logic [WORD_WIDTH-1:0] MAX_N        = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_next;
    logic [4:0]              entry_count;
    logic [4:0]              entry_idx;
    logic [WORD_WIDTH-1:0]   entry_id;
    logic [WORD_WIDTH-1:0]   entry_val;
    logic                    any_valid;
    logic [15:0]             wait_cnt;

    logic                    count_bad;
    logic                    last_entry;
    logic                    entry_self;
    logic                    scan_valid;
    logic                    timeout_hit;

    // N is checked against the raw word before truncation to the 5-bit index.
    assign count_bad   = (mem_data_out == '0) || (mem_data_out > MAX_N);
    assign last_entry  = (entry_idx == (entry_count - 5'd1));
    assign entry_self  = (entry_id == MY_NODE_ID);
    // Includes the entry being evaluated in HOP_D this cycle.
    assign scan_valid  = any_valid || !entry_self;
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next         = state;
        start_winnerPolicy = 1'b0;
        done               = 1'b0;
        busy               = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CNT_A;
                end
            end
            CNT_A: state_next = CNT_D;
            CNT_D: state_next = count_bad ? FIN : ID_A;
            ID_A:  state_next = ID_D;
            ID_D:  state_next = VAL_A;
            VAL_A: state_next = VAL_D;
            VAL_D: state_next = HOP_A;
            HOP_A: state_next = HOP_D;
            HOP_D: begin
                if (!last_entry) begin
                    state_next = ID_A;
                end else if (scan_valid) begin
                    state_next = KICK;
                end else begin
                    state_next = FIN;
                end
            end
            KICK: begin
                start_winnerPolicy = 1'b1;
                state_next         = WAIT;
            end
            WAIT: begin
                if (done_winnerPolicy || timeout_hit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                busy       = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address sequencing, entry capture, evaluation, handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            address             <= '0;
            err                 <= 1'b0;
            bestvalue           <= ALL_ONES;
            besthop             <= ALL_ONES;
            bestneighborID      <= ALL_ONES;
            betterNeighborCount <= '0;
            nexthop             <= ALL_ONES;
            entry_count         <= '0;
            entry_idx           <= '0;
            entry_id            <= '0;
            entry_val           <= '0;
            any_valid           <= 1'b0;
            wait_cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        address             <= TABLE_BASE;
                        err                 <= 1'b0;
                        bestvalue           <= ALL_ONES;
                        besthop             <= ALL_ONES;
                        bestneighborID      <= ALL_ONES;
                        betterNeighborCount <= '0;
                        entry_idx           <= '0;
                        any_valid           <= 1'b0;
                    end
                end
                CNT_D: begin
                    if (count_bad) begin
                        err <= 1'b1;
                    end else begin
                        entry_count <= mem_data_out[4:0];
                        address     <= address + STEP;
                    end
                end
                ID_D: begin
                    entry_id <= mem_data_out;
                    address  <= address + STEP;
                end
                VAL_D: begin
                    entry_val <= mem_data_out;
                    address   <= address + STEP;
                end
                HOP_D: begin
                    // Counting and best tracking are independent tests on the
                    // same entry; strict less-than keeps the earlier entry on ties.
                    if (!entry_self) begin
                        any_valid <= 1'b1;
                        if (entry_val < mybest) begin
                            betterNeighborCount <= betterNeighborCount + WORD_WIDTH'(1);
                        end
                        if (entry_val < bestvalue) begin
                            bestvalue      <= entry_val;
                            besthop        <= mem_data_out;
                            bestneighborID <= entry_id;
                        end
                    end
                    if (last_entry) begin
                        if (!scan_valid) begin
                            err                 <= 1'b1;
                            bestvalue           <= ALL_ONES;
                            besthop             <= ALL_ONES;
                            bestneighborID      <= ALL_ONES;
                            betterNeighborCount <= '0;
                        end
                    end else begin
                        entry_idx <= entry_idx + 5'd1;
                        address   <= address + STEP;
                    end
                end
                KICK: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (done_winnerPolicy) begin
                        nexthop <= nexthop_wp;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        nexthop <= ALL_ONES;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neighbor_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_neighbor_scan
// Purpose  : Directed self-checking bench for neighbor_scan with a word
//            memory model and a winner-policy responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neighbor_scan;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mybest = 16'd0;
    logic [15:0] my_id  = 16'd0;
    logic [15:0] address;
    logic [15:0] mem_data_out = 16'd0;
    logic        start_wp;
    logic        done_wp;
    logic [15:0] nexthop_wp;
    logic [15:0] bestvalue, besthop, bestneighborID, better_cnt, nexthop;
    logic        busy, done, err;

    logic [15:0] wmem [0:63];

    // winner-policy model
    logic        wp_en     = 1'b0;
    int          wp_delay  = 5;
    logic [15:0] wp_hop    = 16'd0;
    int          wp_cnt    = 0;
    logic        model_done = 1'b0;
    logic        manual_done = 1'b0;

    int tests  = 0;
    int fails  = 0;
    int kicks, dones, kick_cyc, done_cyc;
    logic busy_at_done;

    assign done_wp    = model_done | manual_done;
    assign nexthop_wp = wp_hop;

    neighbor_scan dut (
        .clock               (clock),
        .rst                 (rst),
        .start               (start),
        .mybest              (mybest),
        .MY_NODE_ID          (my_id),
        .address             (address),
        .mem_data_out        (mem_data_out),
        .start_winnerPolicy  (start_wp),
        .done_winnerPolicy   (done_wp),
        .nexthop_wp          (nexthop_wp),
        .bestvalue           (bestvalue),
        .besthop             (besthop),
        .bestneighborID      (bestneighborID),
        .betterNeighborCount (better_cnt),
        .nexthop             (nexthop),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: data for an address appears the next cycle.
    always @(posedge clock) begin
        logic [15:0] off;
        off = address - 16'h0100;
        if (off[15:7] == '0) mem_data_out <= wmem[off[6:1]];
        else                 mem_data_out <= 16'd0;
    end

    // Responder: done high in cycle K+wp_delay for a kick in cycle K.
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            wp_cnt     <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (wp_cnt != 0) begin
                if (wp_cnt == 1) model_done <= 1'b1;
                wp_cnt <= wp_cnt - 1;
            end
            if (start_wp && wp_en) wp_cnt <= wp_delay - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_table(input logic [15:0] n, input logic [15:0] e [0:8]);
        for (int i = 0; i < 64; i++) wmem[i] = 16'd0;
        wmem[0] = n;
        for (int i = 0; i < 9; i++) wmem[i+1] = e[i];
    endtask

    // Pulses start (accepted at edge 0), then samples each cycle at the
    // falling edge; cycle c is the c-th cycle after edge 0.
    task automatic run_scan(input int bound, input int inj);
        kicks = 0; dones = 0; kick_cyc = 0; done_cyc = 0; busy_at_done = 1'b1;
        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clock);
            start = (inj != 0) && (c == inj);
            if (start_wp) begin kicks++; kick_cyc = c; end
            if (done) begin dones++; done_cyc = c; busy_at_done = busy; end
            if (dones > 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0;
        check("done_count", dones, 1);
    endtask

    logic [15:0] t_a [0:8] = '{16'd2, 16'd9, 16'd3, 16'd4, 16'd8, 16'd50, 16'd7, 16'd8, 16'd4};
    logic [15:0] t_b [0:8] = '{16'd5, 16'd1, 16'd1, 16'd3, 16'd6, 16'd7, 16'd0, 16'd0, 16'd0};

    initial begin
        for (int i = 0; i < 64; i++) wmem[i] = 16'd0;
        repeat (2) @(negedge clock);
        // reset state
        check("rst_address", address, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_start_wp", start_wp, 0);
        check("rst_bestvalue", bestvalue, 16'hFFFF);
        check("rst_bestid", bestneighborID, 16'hFFFF);
        check("rst_besthop", besthop, 16'hFFFF);
        check("rst_better", better_cnt, 16'd0);
        check("rst_nexthop", nexthop, 16'hFFFF);
        rst = 1'b0;
        @(negedge clock);

        // 1: three entries, all better than mybest
        load_table(16'd3, t_a);
        mybest = 16'd10; my_id = 16'd5; wp_en = 1'b1; wp_delay = 5; wp_hop = 16'd4;
        run_scan(100, 0);
        check("t1_bestid", bestneighborID, 16'd4);
        check("t1_bestvalue", bestvalue, 16'd8);
        check("t1_besthop", besthop, 16'd50);
        check("t1_better", better_cnt, 16'd3);
        check("t1_kick_cycle", kick_cyc, 21);
        check("t1_kicks", kicks, 1);
        check("t1_done_cycle", done_cyc, 27);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_nexthop", nexthop, 16'd4);
        check("t1_err", err, 0);

        // 2: same table, nothing better than mybest
        mybest = 16'd1; wp_hop = 16'd4;
        run_scan(100, 0);
        check("t2_better", better_cnt, 16'd0);
        check("t2_bestid", bestneighborID, 16'd4);
        check("t2_bestvalue", bestvalue, 16'd8);
        check("t2_besthop", besthop, 16'd50);

        // 3: own entry skipped even though it has the lowest value
        load_table(16'd2, t_b);
        mybest = 16'd10; wp_hop = 16'h0033;
        run_scan(100, 0);
        check("t3_bestid", bestneighborID, 16'd3);
        check("t3_bestvalue", bestvalue, 16'd6);
        check("t3_besthop", besthop, 16'd7);
        check("t3_better", better_cnt, 16'd1);
        check("t3_kick_cycle", kick_cyc, 15);
        check("t3_done_cycle", done_cyc, 21);
        check("t3_nexthop", nexthop, 16'h0033);

        // 4: empty table
        load_table(16'd0, t_a);
        run_scan(50, 0);
        check("t4_err", err, 1);
        check("t4_done_cycle", done_cyc, 3);
        check("t4_kicks", kicks, 0);
        check("t4_bestvalue", bestvalue, 16'hFFFF);
        check("t4_bestid", bestneighborID, 16'hFFFF);
        check("t4_besthop", besthop, 16'hFFFF);
        check("t4_better", better_cnt, 16'd0);

        // 5: count above the maximum
        load_table(16'd17, t_a);
        run_scan(50, 0);
        check("t5_err", err, 1);
        check("t5_done_cycle", done_cyc, 3);
        check("t5_kicks", kicks, 0);
        check("t5_bestvalue", bestvalue, 16'hFFFF);

        // 6: responder silent -> timeout; stray start mid-scan ignored
        load_table(16'd3, t_a);
        mybest = 16'd10; wp_en = 1'b0;
        run_scan(400, 6);
        check("t6_err", err, 1);
        check("t6_nexthop", nexthop, 16'hFFFF);
        check("t6_kicks", kicks, 1);
        check("t6_kick_cycle", kick_cyc, 21);
        check("t6_done_cycle", done_cyc, 277);
        check("t6_bestid", bestneighborID, 16'd4);

        // 7: reset while waiting, then a late done from the responder
        kicks = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t7_err_cleared", err, 0);
        check("t7_busy", busy, 1);
        for (int c = 0; c < 60 && kicks == 0; c++) begin
            @(negedge clock);
            if (start_wp) kicks++;
        end
        check("t7_kick_seen", kicks, 1);
        repeat (4) @(negedge clock);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_address", address, 16'h0000);
        check("t7_rst_bestid", bestneighborID, 16'hFFFF);
        check("t7_rst_better", better_cnt, 16'd0);
        check("t7_rst_nexthop", nexthop, 16'hFFFF);
        @(negedge clock);
        rst = 1'b0;
        wp_hop = 16'h00AA;
        manual_done = 1'b1;
        @(negedge clock);
        manual_done = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (done || busy || start_wp) dones++;
        end
        check("t7_no_activity", dones, 0);
        check("t7_nexthop", nexthop, 16'hFFFF);
        check("t7_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
